dmem_lsu: RTL
=============

Name: dmem_lsu

Overview:
Load/store initiator for the RISC datapath's data memory. Accepts one load or store at a time from the execute stage over a valid/ready request channel and drives the data memory's shared address, write and read-enable signals. It registers the read data and returns a response over a valid/ready channel. Configurable wait states model slower memory without changing the datapath handshake.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, request/memory address width
DEPTH, 8, number of data-memory words (used by bounds check)
WAIT_CYCLES, 0, extra ACCESS cycles before commit/sample (0..15)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  LSU can accept request
req_we  in  1  1=store, 0=load
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  store data
rsp_valid  out  1  response present
rsp_ready  in  1  datapath accepts response
rsp_rdata  out  DATA_W  load data (0 for stores)
rsp_err  out  1  out-of-range access (feature only, else 0)
mem_access_addr  out  ADDR_W  memory address
mem_write_data  out  DATA_W  memory write data
mem_write_en  out  1  memory write strobe (memory writes on posedge)
mem_read  out  1  memory read enable
mem_read_data  in  DATA_W  combinational memory read data

Behaviour:
- Reset (async, rst_n=0): state=IDLE, wait counter=0, captured addr/wdata/we=0, rsp_rdata=0, rsp_err=0. Outputs: req_ready=1, rsp_valid=0, mem_write_en=0, mem_read=0, mem_access_addr=0, mem_write_data=0.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready at edge T0, capture we/addr/wdata, load counter=WAIT_CYCLES, go to ACCESS.
  - ACCESS: req_ready=0. mem_access_addr and mem_write_data come from the captured registers. mem_read=~we for every ACCESS cycle. Counter decrements each cycle while nonzero.
    - Final ACCESS cycle (counter==0), store: mem_write_en=1 for exactly this one cycle; the write commits at the closing edge.
    - Final ACCESS cycle, load: sample mem_read_data into rsp_rdata at the closing edge.
    - Go to RESP after the final ACCESS cycle.
  - RESP: rsp_valid=1, with rsp_rdata and rsp_err held stable. On rsp_ready, go to IDLE. rsp_rdata is cleared to 0 for stores.
- Latency: ACCESS lasts WAIT_CYCLES+1 cycles. rsp_valid rises after edge T0+WAIT_CYCLES+1. Minimum request-to-request spacing is WAIT_CYCLES+3 cycles.
- mem_write_en and mem_read are never both 1, and both are 0 outside ACCESS. Address/data outputs hold their captured values outside ACCESS.
- rsp_valid is held until rsp_ready; back-pressure of any length is legal, with no timeout.
- req_valid asserted outside IDLE is ignored (req_ready=0). Its inputs need not be stable.
- Async reset mid-ACCESS drops mem_write_en immediately; a store not yet at its commit edge is lost. Reset mid-RESP discards the response.
- Full ADDR_W address is driven; the memory decodes the low bits itself.

Optional Feature:
DMEM_LSU_BOUNDS_CHECK_EN
- Defined: at capture, req_addr >= DEPTH sets the error flag. An erroring store keeps mem_write_en=0 through ACCESS. An erroring load keeps mem_read=0 and returns rsp_rdata=0. rsp_err=1 in RESP. ACCESS timing is unchanged.
- Undefined: no check is made; out-of-range addresses alias in memory and rsp_err is tied to 0.

Test Plan:
- Store addr 0x0003 data 0x1234 (WAIT_CYCLES=0), rsp_ready=1 -> mem_write_en high exactly 1 cycle with addr 0x0003; rsp_valid 1 cycle after accept; rsp_rdata=0; a following load of 0x0003 returns 0x1234.
- WAIT_CYCLES=2, load addr 0x0005 holding 0xBEEF -> mem_read high 3 cycles; rsp_valid after edge T0+3; rsp_rdata=0xBEEF; req_ready=0 from T0 until return to IDLE.
- Load response with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable for all 5 cycles; a second req_valid in that window is not accepted; IDLE is entered the cycle after rsp_ready=1.
- Store 0x00FF to addr 0x0002 with rst_n pulsed low during ACCESS (WAIT_CYCLES=2) -> mem_write_en drops asynchronously; memory[2] unchanged; after release req_ready=1 and rsp_valid=0.
- Feature on, store 0xAAAA to addr 0x0009 -> mem_write_en stays 0, rsp_err=1, memory[1] unchanged. Feature off, same stimulus -> mem_write_en pulses, rsp_err=0, memory[1]=0xAAAA.
- Back-to-back alternating store/load to addrs 0..7 -> all readbacks match; mem_write_en and mem_read are never high together.

Source files
------------

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - single-outstanding load/store initiator for the data memory
// Optional feature macro: DMEM_LSU_BOUNDS_CHECK_EN (out-of-range accesses flagged and suppressed)
module dmem_lsu #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 8,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

`ifdef DMEM_LSU_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       cap_we;
    logic       cap_err;
    logic       req_err;

    assign req_err = BOUNDS_EN && (req_addr >= DEPTH_A);

    // mem_access_addr / mem_write_data double as the captured request registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            cnt             <= 4'd0;
            cap_we          <= 1'b0;
            cap_err         <= 1'b0;
            req_ready       <= 1'b1;
            rsp_valid       <= 1'b0;
            rsp_rdata       <= '0;
            rsp_err         <= 1'b0;
            mem_access_addr <= '0;
            mem_write_data  <= '0;
            mem_write_en    <= 1'b0;
            mem_read        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state           <= ACCESS;
                        req_ready       <= 1'b0;
                        cap_we          <= req_we;
                        cap_err         <= req_err;
                        cnt             <= WAIT_INIT;
                        mem_access_addr <= req_addr;
                        mem_write_data  <= req_wdata;
                        mem_read        <= !req_we && !req_err;
                        mem_write_en    <= req_we && !req_err && (WAIT_INIT == 4'd0);
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt          <= cnt - 4'd1;
                        // strobe only in the final ACCESS cycle so the write commits once
                        mem_write_en <= cap_we && !cap_err && (cnt == 4'd1);
                    end else begin
                        state        <= RESP;
                        mem_write_en <= 1'b0;
                        mem_read     <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_rdata    <= (cap_we || cap_err) ? '0 : mem_read_data;
                        rsp_err      <= cap_err;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state        <= IDLE;
                    req_ready    <= 1'b1;
                    rsp_valid    <= 1'b0;
                    mem_write_en <= 1'b0;
                    mem_read     <= 1'b0;
                end
            endcase
        end
    end

endmodule
